// File: rtl/armleocpu_alu_issue_pkg.sv
// Shared ALU select codes, opcode constants and the issue bundle type.
// Also holds the funct3 -> ALU select mapping shared by OP and OP-IMM.
package armleocpu_alu_issue_pkg;

   localparam int ARMLEOCPU_ALU_SELECT_WIDTH = 4;

   localparam logic [ARMLEOCPU_ALU_SELECT_WIDTH-1:0] ALU_SEL_ADD  = 4'd0;
   localparam logic [ARMLEOCPU_ALU_SELECT_WIDTH-1:0] ALU_SEL_SUB  = 4'd1;
   localparam logic [ARMLEOCPU_ALU_SELECT_WIDTH-1:0] ALU_SEL_SLT  = 4'd2;
   localparam logic [ARMLEOCPU_ALU_SELECT_WIDTH-1:0] ALU_SEL_SLTU = 4'd3;
   localparam logic [ARMLEOCPU_ALU_SELECT_WIDTH-1:0] ALU_SEL_SLL  = 4'd4;
   localparam logic [ARMLEOCPU_ALU_SELECT_WIDTH-1:0] ALU_SEL_SRA  = 4'd5;
   localparam logic [ARMLEOCPU_ALU_SELECT_WIDTH-1:0] ALU_SEL_SRL  = 4'd6;
   localparam logic [ARMLEOCPU_ALU_SELECT_WIDTH-1:0] ALU_SEL_XOR  = 4'd7;
   localparam logic [ARMLEOCPU_ALU_SELECT_WIDTH-1:0] ALU_SEL_OR   = 4'd8;
   localparam logic [ARMLEOCPU_ALU_SELECT_WIDTH-1:0] ALU_SEL_AND  = 4'd9;

   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

   typedef struct packed {
      logic [ARMLEOCPU_ALU_SELECT_WIDTH-1:0] select_result;
      logic        select_imm;
      logic        shamt_sel;
      logic [4:0]  shamt;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  rd;
      logic        illegal;
   } alu_bundle_t;

   // alt is instr[30]; allow_sub is false for OP-IMM, where 000 is always ADDI.
   function automatic logic [ARMLEOCPU_ALU_SELECT_WIDTH-1:0] alu_select_from_funct3(
      input logic [2:0] funct3,
      input logic       alt,
      input logic       allow_sub
   );
      logic [ARMLEOCPU_ALU_SELECT_WIDTH-1:0] sel;
      case (funct3)
         3'b000:  sel = (alt && allow_sub) ? ALU_SEL_SUB : ALU_SEL_ADD;
         3'b001:  sel = ALU_SEL_SLL;
         3'b010:  sel = ALU_SEL_SLT;
         3'b011:  sel = ALU_SEL_SLTU;
         3'b100:  sel = ALU_SEL_XOR;
         3'b101:  sel = alt ? ALU_SEL_SRA : ALU_SEL_SRL;
         3'b110:  sel = ALU_SEL_OR;
         default: sel = ALU_SEL_AND;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/armleocpu_alu_issue_decode.sv
// Combinational decode of OP / OP-IMM / LUI / AUIPC into an ALU bundle.
// ARMLEOCPU_ALU_ISSUE_ILLEGAL_CHECK_EN enables illegal-encoding detection.
module armleocpu_alu_issue_decode
   import armleocpu_alu_issue_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output alu_bundle_t bundle
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       illegal;
   logic       unused_bits;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   // rs1 index is resolved upstream; only its data arrives here.
   assign unused_bits = ^{instr[19:15], funct7};

   always_comb begin
      bundle               = '0;
      bundle.select_result = ALU_SEL_ADD;
      bundle.shamt         = instr[24:20];
      bundle.rd            = instr[11:7];
      illegal              = 1'b0;
      case (opcode)
         OPCODE_OP: begin
            bundle.op1           = rs1_data;
            bundle.op2           = rs2_data;
            bundle.shamt_sel     = 1'b1;
            bundle.select_result = alu_select_from_funct3(funct3, instr[30], 1'b1);
`ifdef ARMLEOCPU_ALU_ISSUE_ILLEGAL_CHECK_EN
            illegal = !((funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
`endif
         end
         OPCODE_OP_IMM: begin
            bundle.op1           = rs1_data;
            bundle.op2           = {{20{instr[31]}}, instr[31:20]};
            bundle.select_imm    = 1'b1;
            bundle.select_result = alu_select_from_funct3(funct3, instr[30], 1'b0);
`ifdef ARMLEOCPU_ALU_ISSUE_ILLEGAL_CHECK_EN
            if (funct3 == 3'b001)
               illegal = (funct7 != 7'b0000000);
            else if (funct3 == 3'b101)
               illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
`endif
         end
         OPCODE_LUI: begin
            bundle.op2        = {instr[31:12], 12'b0};
            bundle.select_imm = 1'b1;
         end
         OPCODE_AUIPC: begin
            bundle.op1        = pc;
            bundle.op2        = {instr[31:12], 12'b0};
            bundle.select_imm = 1'b1;
         end
         default: begin
`ifdef ARMLEOCPU_ALU_ISSUE_ILLEGAL_CHECK_EN
            illegal = 1'b1;
`endif
         end
      endcase
      // Illegal entries reach the ALU as a harmless 0 + 0.
      if (illegal) begin
         bundle.select_result = ALU_SEL_ADD;
         bundle.op1           = '0;
         bundle.op2           = '0;
      end
      bundle.illegal = illegal;
   end

endmodule

// File: rtl/armleocpu_alu_issue.sv
// ALU issue stage: decode feeding a two-entry skid buffer (main + skid).
// Optional illegal-encoding check: ARMLEOCPU_ALU_ISSUE_ILLEGAL_CHECK_EN.
module armleocpu_alu_issue
   import armleocpu_alu_issue_pkg::*;
#(
   parameter bit RESET_IN_READY = 1'b1
)(
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  flush,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [31:0]                           in_instr,
   input  logic [31:0]                           in_pc,
   input  logic [31:0]                           in_rs1_data,
   input  logic [31:0]                           in_rs2_data,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [ARMLEOCPU_ALU_SELECT_WIDTH-1:0] out_select_result,
   output logic                                  out_select_imm,
   output logic                                  out_shamt_sel,
   output logic [4:0]                            out_shamt,
   output logic [31:0]                           out_op1,
   output logic [31:0]                           out_op2,
   output logic [4:0]                            out_rd,
   output logic                                  out_illegal
);

   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} issue_state_t;

   issue_state_t state_reg, state_next;
   logic         in_ready_reg, in_ready_next;
   alu_bundle_t  main_reg, skid_reg, dec_bundle;
   logic         in_fire, out_fire;
   logic         main_load_dec, main_load_skid, skid_load;

   armleocpu_alu_issue_decode u_decode (
      .instr    (in_instr),
      .pc       (in_pc),
      .rs1_data (in_rs1_data),
      .rs2_data (in_rs2_data),
      .bundle   (dec_bundle)
   );

   assign in_fire  = in_valid && in_ready_reg;
   assign out_fire = out_valid && out_ready;

   always_comb begin
      state_next     = state_reg;
      main_load_dec  = 1'b0;
      main_load_skid = 1'b0;
      skid_load      = 1'b0;
      case (state_reg)
         ST_EMPTY: if (in_fire) begin
            state_next    = ST_ONE;
            main_load_dec = 1'b1;
         end
         ST_ONE: begin
            if (in_fire && out_fire) begin
               main_load_dec = 1'b1;
            end else if (in_fire) begin
               state_next = ST_TWO;
               skid_load  = 1'b1;
            end else if (out_fire) begin
               state_next = ST_EMPTY;
            end
         end
         ST_TWO: if (out_fire) begin
            state_next     = ST_ONE;
            main_load_skid = 1'b1;
         end
         default: state_next = ST_EMPTY;
      endcase
      // Flush drops everything, including a same-cycle input.
      if (flush) begin
         state_next     = ST_EMPTY;
         main_load_dec  = 1'b0;
         main_load_skid = 1'b0;
         skid_load      = 1'b0;
      end
      in_ready_next = (state_next != ST_TWO);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_EMPTY;
         in_ready_reg <= RESET_IN_READY;
         main_reg     <= '0;
         skid_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         in_ready_reg <= in_ready_next;
         if (main_load_dec)
            main_reg <= dec_bundle;
         else if (main_load_skid)
            main_reg <= skid_reg;
         if (skid_load)
            skid_reg <= dec_bundle;
      end
   end

   assign in_ready          = in_ready_reg;
   assign out_valid         = (state_reg != ST_EMPTY);
   assign out_select_result = main_reg.select_result;
   assign out_select_imm    = main_reg.select_imm;
   assign out_shamt_sel     = main_reg.shamt_sel;
   assign out_shamt         = main_reg.shamt;
   assign out_op1           = main_reg.op1;
   assign out_op2           = main_reg.op2;
   assign out_rd            = main_reg.rd;
   assign out_illegal       = main_reg.illegal;

endmodule

// File: tb/tb_armleocpu_alu_issue.sv
// Directed bench for armleocpu_alu_issue; honours ARMLEOCPU_ALU_ISSUE_ILLEGAL_CHECK_EN.
module tb_armleocpu_alu_issue;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
   logic [3:0]  out_select_result;
   logic        out_select_imm, out_shamt_sel, out_illegal;
   logic [4:0]  out_shamt, out_rd;
   logic [31:0] out_op1, out_op2;

   int checks_cnt = 0;
   int fail_cnt   = 0;

   always #5 clk = ~clk;

   armleocpu_alu_issue #(.RESET_IN_READY(1'b1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_select_result(out_select_result), .out_select_imm(out_select_imm),
      .out_shamt_sel(out_shamt_sel), .out_shamt(out_shamt),
      .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
      .out_illegal(out_illegal)
   );

   task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks_cnt++;
      if (actual !== expected) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end else begin
         $display("ok   %s = 0x%08h", tag, actual);
      end
   endtask

   // Inputs change at negedge; one posedge passes; outputs are sampled at the next negedge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic valid, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2);
      in_valid    = valid;
      in_instr    = instr;
      in_pc       = pc;
      in_rs1_data = rs1;
      in_rs2_data = rs2;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b1, 32'h40208033, 32'h0, 32'd1, 32'd2);
      @(negedge clk);
      step();
      check_eq("rst out_valid", {31'b0, out_valid}, 32'd0);
      check_eq("rst in_ready", {31'b0, in_ready}, 32'd1);
      check_eq("rst op1", out_op1, 32'd0);
      check_eq("rst select", {28'b0, out_select_result}, 32'd0);

      // SUB x0,x1,x2
      rst = 1'b0; out_ready = 1'b1;
      drive(1'b1, 32'h40208033, 32'h0, 32'd10, 32'd3);
      step();
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      check_eq("sub out_valid", {31'b0, out_valid}, 32'd1);
      check_eq("sub select", {28'b0, out_select_result}, 32'd1);
      check_eq("sub op1", out_op1, 32'd10);
      check_eq("sub op2", out_op2, 32'd3);
      check_eq("sub select_imm", {31'b0, out_select_imm}, 32'd0);
      check_eq("sub shamt_sel", {31'b0, out_shamt_sel}, 32'd1);
      step();
      check_eq("sub drained", {31'b0, out_valid}, 32'd0);

      // ADDI x1,x0,-1
      drive(1'b1, 32'hFFF00093, 32'h0, 32'd0, 32'd7);
      step();
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      check_eq("addi select", {28'b0, out_select_result}, 32'd0);
      check_eq("addi op2", out_op2, 32'hFFFFFFFF);
      check_eq("addi select_imm", {31'b0, out_select_imm}, 32'd1);
      check_eq("addi shamt_sel", {31'b0, out_shamt_sel}, 32'd0);
      check_eq("addi rd", {27'b0, out_rd}, 32'd1);
      step();

      // AUIPC x1,0x12345 at pc 0x1000
      drive(1'b1, 32'h12345097, 32'h1000, 32'hDEAD, 32'hBEEF);
      step();
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      check_eq("auipc op1", out_op1, 32'h1000);
      check_eq("auipc op2", out_op2, 32'h12345000);
      check_eq("auipc select", {28'b0, out_select_result}, 32'd0);
      step();

      // Back-to-back: SRAI x2,x1,3 then LUI x1,0xABCDE
      drive(1'b1, 32'h4030D113, 32'h0, 32'h80000000, 32'h0);
      step();
      check_eq("srai select", {28'b0, out_select_result}, 32'd5);
      check_eq("srai op2", out_op2, 32'h00000403);
      check_eq("srai shamt", {27'b0, out_shamt}, 32'd3);
      check_eq("srai op1", out_op1, 32'h80000000);
      drive(1'b1, 32'hABCDE0B7, 32'h0, 32'h1234, 32'h0);
      step();
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      check_eq("lui out_valid", {31'b0, out_valid}, 32'd1);
      check_eq("lui op1", out_op1, 32'd0);
      check_eq("lui op2", out_op2, 32'hABCDE000);
      check_eq("lui rd", {27'b0, out_rd}, 32'd1);
      step();
      check_eq("b2b drained", {31'b0, out_valid}, 32'd0);

      // Backpressure: XOR x3, OR x4, AND x5 offered with out_ready low
      out_ready = 1'b0;
      drive(1'b1, 32'h0020C1B3, 32'h0, 32'h55, 32'hF0);
      step();
      check_eq("bp first in_ready", {31'b0, in_ready}, 32'd1);
      check_eq("bp first rd", {27'b0, out_rd}, 32'd3);
      drive(1'b1, 32'h0020E233, 32'h0, 32'h11, 32'h22);
      step();
      check_eq("bp full in_ready", {31'b0, in_ready}, 32'd0);
      check_eq("bp hold rd", {27'b0, out_rd}, 32'd3);
      drive(1'b1, 32'h0020F2B3, 32'h0, 32'h33, 32'h44);
      step();
      check_eq("bp stall rd", {27'b0, out_rd}, 32'd3);
      check_eq("bp stall op1", out_op1, 32'h55);
      check_eq("bp stall select", {28'b0, out_select_result}, 32'd7);
      check_eq("bp stall in_ready", {31'b0, in_ready}, 32'd0);
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      out_ready = 1'b1;
      step();
      check_eq("bp second valid", {31'b0, out_valid}, 32'd1);
      check_eq("bp second rd", {27'b0, out_rd}, 32'd4);
      check_eq("bp second op1", out_op1, 32'h11);
      check_eq("bp second select", {28'b0, out_select_result}, 32'd8);
      check_eq("bp reopen in_ready", {31'b0, in_ready}, 32'd1);
      step();
      check_eq("bp drained", {31'b0, out_valid}, 32'd0);

      // Flush while full with an input offered
      out_ready = 1'b0;
      drive(1'b1, 32'h0020C1B3, 32'h0, 32'h55, 32'hF0);
      step();
      drive(1'b1, 32'h0020E233, 32'h0, 32'h11, 32'h22);
      step();
      flush = 1'b1;
      drive(1'b1, 32'h0020F2B3, 32'h0, 32'h33, 32'h44);
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      check_eq("flush out_valid", {31'b0, out_valid}, 32'd0);
      check_eq("flush in_ready", {31'b0, in_ready}, 32'd1);
      out_ready = 1'b1;
      step();
      check_eq("flush nothing delivered", {31'b0, out_valid}, 32'd0);

      // Unsupported opcode 0x7F
      drive(1'b1, 32'h0000007F, 32'h0, 32'd5, 32'd6);
      step();
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
`ifdef ARMLEOCPU_ALU_ISSUE_ILLEGAL_CHECK_EN
      check_eq("bad opcode illegal", {31'b0, out_illegal}, 32'd1);
`else
      check_eq("bad opcode illegal", {31'b0, out_illegal}, 32'd0);
`endif
      check_eq("bad opcode op1", out_op1, 32'd0);
      check_eq("bad opcode op2", out_op2, 32'd0);
      check_eq("bad opcode select", {28'b0, out_select_result}, 32'd0);
      step();

      // OP with funct7=0000001 and funct3=100
      drive(1'b1, 32'h0220C1B3, 32'h0, 32'h55, 32'hF0);
      step();
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
`ifdef ARMLEOCPU_ALU_ISSUE_ILLEGAL_CHECK_EN
      check_eq("bad funct7 illegal", {31'b0, out_illegal}, 32'd1);
      check_eq("bad funct7 select", {28'b0, out_select_result}, 32'd0);
      check_eq("bad funct7 op1", out_op1, 32'd0);
`else
      check_eq("bad funct7 illegal", {31'b0, out_illegal}, 32'd0);
      check_eq("bad funct7 select", {28'b0, out_select_result}, 32'd7);
      check_eq("bad funct7 op1", out_op1, 32'h55);
`endif
      step();

      // Reset mid-operation clears state and data
      out_ready = 1'b0;
      drive(1'b1, 32'h0020C1B3, 32'h0, 32'h55, 32'hF0);
      step();
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      check_eq("pre-rst valid", {31'b0, out_valid}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("mid rst out_valid", {31'b0, out_valid}, 32'd0);
      check_eq("mid rst op1", out_op1, 32'd0);
      check_eq("mid rst in_ready", {31'b0, in_ready}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks_cnt, fail_cnt);
      $finish;
   end

endmodule
